// File: rtl/ss_scan_driver.sv
// ss_scan_driver: time-multiplexed driver for a 4-digit seven-segment display.
// Posted data (value, decimal points, blank mask) is double-buffered and
// reaches the display only at frame boundaries. Every digit slot starts with
// a short all-off window that suppresses ghosting.
// Optional feature: define SS_BLINK_EN to add per-digit blinking through
// blink_mask. Without it, blink_mask is ignored and no blink logic is built.
module ss_scan_driver #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    output logic [7:0]  ssDisp,
    output logic [3:0]  ssSel,
    output logic        frame_tick,
    output logic        pending
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          boundary;

    logic [15:0]   pend_value;
    logic [3:0]    pend_dp;
    logic [3:0]    pend_blank;
    logic [15:0]   act_value;
    logic [3:0]    act_dp;
    logic [3:0]    act_blank;

    logic [3:0]    nibble;
    logic [6:0]    seg;
    logic          in_gap;
    logic          digit_dark;

    // Frame boundary: last cycle of the last digit slot.
    assign boundary = (idx == 2'd3) && (cnt == CNT_LAST);

    // Hex digit to segments g..a.
    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        case (h)
            4'h0: hex7seg = 7'h3F;
            4'h1: hex7seg = 7'h06;
            4'h2: hex7seg = 7'h5B;
            4'h3: hex7seg = 7'h4F;
            4'h4: hex7seg = 7'h66;
            4'h5: hex7seg = 7'h6D;
            4'h6: hex7seg = 7'h7D;
            4'h7: hex7seg = 7'h07;
            4'h8: hex7seg = 7'h7F;
            4'h9: hex7seg = 7'h6F;
            4'hA: hex7seg = 7'h77;
            4'hB: hex7seg = 7'h7C;
            4'hC: hex7seg = 7'h39;
            4'hD: hex7seg = 7'h5E;
            4'hE: hex7seg = 7'h79;
            default: hex7seg = 7'h71;
        endcase
    endfunction

`ifdef SS_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [3:0]    pend_blink;
    logic [3:0]    act_blink;
    logic          blink_on;
    logic [BW-1:0] blink_cnt;

    // Blink phase flips after every BLINK_FRAMES frame boundaries; loads do not touch it.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_on  <= 1'b1;
            blink_cnt <= '0;
        end else if (boundary) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Blink-mask half of the double buffer, same transfer rules as the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_blink <= '0;
            act_blink  <= '0;
        end else begin
            if (load && !boundary) pend_blink <= blink_mask;
            if (boundary && load)  act_blink  <= blink_mask;
            else if (boundary && pending) act_blink <= pend_blink;
        end
    end

    assign digit_dark = act_blank[idx] | (act_blink[idx] & ~blink_on);
`else
    logic unused_blink;
    assign unused_blink = &{1'b0, blink_mask, BLINK_FRAMES[0]};
    assign digit_dark   = act_blank[idx];
`endif

    assign nibble = act_value[{idx, 2'b00} +: 4];
    assign seg    = hex7seg(nibble);
    assign in_gap = (int'(cnt) < BLANK_CYCLES);

    // Slot counter and digit index; idx advances when cnt wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: loads land in pending, pending moves to active at the boundary;
    // a load on the boundary cycle bypasses straight to active.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            act_value  <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load && !boundary) begin
                pend_value <= value;
                pend_dp    <= dp_mask;
                pend_blank <= blank_mask;
            end
            if (boundary && load) begin
                act_value <= value;
                act_dp    <= dp_mask;
                act_blank <= blank_mask;
            end else if (boundary && pending) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                act_blank <= pend_blank;
            end
            if (load)          pending <= !boundary;
            else if (boundary) pending <= 1'b0;
        end
    end

    // Registered pin pattern for the current (idx, cnt) state.
    always_ff @(posedge clk) begin
        if (reset) begin
            ssSel      <= 4'b1111;
            ssDisp     <= 8'h00;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= boundary;
            if (in_gap) begin
                ssSel  <= 4'b1111;
                ssDisp <= 8'h00;
            end else begin
                ssSel  <= ~(4'b0001 << idx);
                ssDisp <= digit_dark ? 8'h00 : {act_dp[idx], seg};
            end
        end
    end

endmodule

// File: tb/tb_ss_scan_driver.sv
// Bench for ss_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
// Each output cycle is compared against {frame_tick, pending, ssSel, ssDisp}
// expectations built from the scan position and hand-computed digit patterns.
module tb_ss_scan_driver;
    localparam int RD = 8;
    localparam int BL = 2;
    localparam int BF = 2;
    localparam int FRAME = 4 * RD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic [7:0]  ssDisp;
    logic [3:0]  ssSel;
    logic        frame_tick;
    logic        pending;

    ss_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .blink_mask(blink_mask),
        .ssDisp(ssDisp), .ssSel(ssSel), .frame_tick(frame_tick), .pending(pending)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [31:0] exp;   // {digit3, digit2, digit1, digit0} segment bytes
    } vec_t;

    vec_t        vecs[7];
    logic [13:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          frame_num = 0;
    logic        model_pend = 1'b0;

    // Scoreboard pop and compare against {tick, pending, sel, disp}.
    task automatic check_out(input string name, input int p);
        logic [13:0] exp;
        logic [13:0] act;
        act = {frame_tick, pending, ssSel, ssDisp};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s p=%0d: scoreboard empty, got %h", name, p, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s p=%0d: got tick=%b pend=%b sel=%b disp=%h, want tick=%b pend=%b sel=%b disp=%h",
                         name, p, act[13], act[12], act[11:8], act[7:0],
                         exp[13], exp[12], exp[11:8], exp[7:0]);
            end
        end
    endtask

    // Expected pin pattern for scan position p of the current frame.
    function automatic logic [13:0] expect_at(input int p, input logic [31:0] digits,
                                              input logic [3:0] cur_blink, input logic pend);
        int d;
        int c;
        logic [3:0] sel;
        logic [7:0] disp;
        d = p / RD;
        c = p % RD;
        if (c < BL) begin
            sel  = 4'b1111;
            disp = 8'h00;
        end else begin
            sel  = ~(4'b0001 << d);
            disp = digits[8*d +: 8];
`ifdef SS_BLINK_EN
            if (cur_blink[d] && ((frame_num / BF) % 2 == 1)) disp = 8'h00;
`else
            if (cur_blink[d] && 1'b0) disp = 8'h00;
`endif
        end
        return {(p == FRAME - 1), pend, sel, disp};
    endfunction

    // Drive one frame (or its first stop_at cycles) with up to two loads.
    task automatic run_frame(input string name, input logic [31:0] digits, input logic [3:0] cur_blink,
                             input int stop_at,
                             input int lp_a, input logic [15:0] va, input logic [3:0] dpa,
                             input logic [3:0] bla, input logic [3:0] bka,
                             input int lp_b, input logic [15:0] vb);
        for (int p = 0; p < stop_at; p++) begin
            if (p == lp_a) begin
                load = 1'b1; value = va; dp_mask = dpa; blank_mask = bla; blink_mask = bka;
                model_pend = (p != FRAME - 1);
            end else if (p == lp_b) begin
                load = 1'b1; value = vb; dp_mask = '0; blank_mask = '0; blink_mask = '0;
                model_pend = (p != FRAME - 1);
            end else if (p == FRAME - 1) begin
                model_pend = 1'b0;
            end
            exp_q.push_back(expect_at(p, digits, cur_blink, model_pend));
            @(posedge clk);
            #1 load = 1'b0;
            @(negedge clk);
            check_out(name, p);
        end
        if (stop_at == FRAME) frame_num++;
    endtask

    // Reset pulse followed by a check of the reset pin state.
    task automatic do_reset(input string name, input int cycles);
        reset = 1'b1;
        load  = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 reset = 1'b0;
        model_pend = 1'b0;
        frame_num  = 0;
        exp_q.push_back({1'b0, 1'b0, 4'b1111, 8'h00});
        @(negedge clk);
        check_out(name, -1);
    endtask

    initial begin
        logic [31:0] shown;
        logic [3:0]  shown_blink;

        vecs[0] = '{16'h1A2F, 4'b0100, 4'b0000, 4'b0000, 32'h06F75B71};
        vecs[1] = '{16'h3210, 4'b0000, 4'b0000, 4'b0000, 32'h4F5B063F};
        vecs[2] = '{16'h7654, 4'b1111, 4'b0000, 4'b0000, 32'h87FDEDE6};
        vecs[3] = '{16'hBA98, 4'b0000, 4'b0000, 4'b0000, 32'h7C776F7F};
        vecs[4] = '{16'hFEDC, 4'b0001, 4'b1000, 4'b0000, 32'h00795EB9};
        vecs[5] = '{16'h8888, 4'b1111, 4'b1111, 4'b0000, 32'h00000000};
        vecs[6] = '{16'h0000, 4'b0000, 4'b0000, 4'b0001, 32'h3F3F3F3F};

        do_reset("reset", 3);

        // Power-on frame: active registers are zero, so every digit shows 0.
        shown = 32'h3F3F3F3F;
        shown_blink = 4'b0000;
        run_frame("idle", shown, shown_blink, FRAME, -1, '0, '0, '0, '0, -1, '0);

        // Table: load mid-frame at a random slot, the following frame shows it.
        for (int i = 0; i < 7; i++) begin
            run_frame("table", shown, shown_blink, FRAME, $urandom_range(1, FRAME - 2),
                      vecs[i].value, vecs[i].dp, vecs[i].blank, vecs[i].blink, -1, '0);
            shown       = vecs[i].exp;
            shown_blink = vecs[i].blink;
        end

        // Blink mask on digit 0 held over several frames.
        for (int f = 0; f < 4; f++)
            run_frame("blink", shown, shown_blink, FRAME, -1, '0, '0, '0, '0, -1, '0);

        // Two loads in one frame; the second lands on the boundary and wins.
        run_frame("double_load", shown, shown_blink, FRAME, 10, 16'h1111, '0, '0, '0, FRAME - 1, 16'h2222);
        shown = 32'h5B5B5B5B;
        shown_blink = 4'b0000;
        run_frame("after_double", shown, shown_blink, FRAME, -1, '0, '0, '0, '0, -1, '0);

        // Reset mid-slot with data pending: pending data is discarded.
        run_frame("pre_reset", shown, shown_blink, 13, 5, 16'h5555, 4'b1111, '0, '0, -1, '0);
        do_reset("mid_reset", 1);
        shown = 32'h3F3F3F3F;
        run_frame("post_reset", shown, shown_blink, FRAME, -1, '0, '0, '0, '0, -1, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ss_scan_driver.md
# ss_scan_driver

- Time-multiplexed driver for the 4-digit seven-segment display: converts a 16-bit hex value plus per-digit decimal-point and blank masks into the scanned `ssDisp`/`ssSel` pin pattern.
- Output-side counterpart of the button debounce/edge path: game logic posts display data with a one-cycle `load` strobe and this block owns the display pins.
- Double-buffers the posted data so updates land only on frame boundaries (no tearing).
- Inserts a blanking gap at every digit switch to suppress ghosting.

## Interface
Parameters:
- `REFRESH_DIV`, 1000: clk cycles per digit slot; must be ≥ `BLANK_CYCLES`+1.
- `BLANK_CYCLES`, 2: cycles at the start of each slot with all digits off; 0 allowed.
- `BLINK_FRAMES`, 64: frames per blink half-period; only used with `SS_BLINK_EN`.

Ports:
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `load` input 1: one-cycle strobe; captures `value`, `dp_mask`, `blank_mask`, `blink_mask`.
- `value` input 16: digit n = `value[4n+3:4n]`; digit 0 is rightmost.
- `dp_mask` input 4: bit n lights the DP of digit n.
- `blank_mask` input 4: bit n forces digit n fully dark.
- `blink_mask` input 4: bit n blinks digit n.
- `ssDisp` output 8: segments, active-high; bit0..6 = a..g, bit7 = dp.
- `ssSel` output 4: digit enables, active-low one-hot; bit n = digit n.
- `frame_tick` output 1: one-cycle pulse on the last cycle of each frame.
- `pending` output 1: high while loaded data awaits transfer.

## Operation
- State:
  - slot counter `cnt` (0..`REFRESH_DIV`-1)
  - digit index `idx` (0..3)
  - pending register + `pending` flag
  - active register
  - blink phase + frame counter (macro only)
- `cnt` increments every cycle. When it wraps, `idx` increments (3 wraps to 0).
- A frame is 4·`REFRESH_DIV` cycles.
- Frame boundary = cycle with `idx`=3 and `cnt`=`REFRESH_DIV`-1; `frame_tick` is 1 in exactly this state.
- On `load`, the inputs are written to the pending register and `pending` is set. If several loads occur in one frame, the last one wins.
- At the frame boundary with `pending`=1: active ← pending register, `pending` clears.
- `load` in the same cycle as the boundary: the `load` inputs are written straight into active, and `pending` ends low.
- Pattern for digit `idx`:
  - During the blank window (`cnt` < `BLANK_CYCLES`): `ssSel`=4'b1111, `ssDisp`=8'h00.
  - Otherwise: `ssSel` has only bit `idx` low.
  - If the digit is blanked: `ssDisp`=8'h00, and `ssSel` still selects the digit.
  - If not blanked: `ssDisp` = {dp bit, hex7seg(nibble)}.
- hex7seg (bits g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Reset:
  - `cnt`=0, `idx`=0.
  - Pending and active registers all zero; `pending`=0.
  - `ssSel`=4'b1111, `ssDisp`=8'h00, `frame_tick`=0.
  - Blink phase = on, blink counter 0.
- Reset asserted mid-frame or mid-load: everything returns to reset values on that edge. Any pending data is discarded.

## Timing
- `ssSel`, `ssDisp` and `frame_tick` are registered and reflect the (`idx`,`cnt`) state of the previous cycle (one-cycle latency).
- The first edge with `reset` low has state `cnt`=0. Digit 0 first appears at the output `BLANK_CYCLES`+1 edges after that.
- A digit is lit for `REFRESH_DIV`-`BLANK_CYCLES` consecutive cycles per slot.
- Latency from a `load` to the new data on the pins: at most one frame plus the blank window of digit 0, plus 1 cycle.
- `pending` rises on the edge after `load`. It falls on the edge after the boundary.
- `BLANK_CYCLES`=0: no gap; `ssSel` switches directly between adjacent digits.

## Configuration
- Macro `SS_BLINK_EN`.
- Defined:
  - A frame counter toggles the blink phase every `BLINK_FRAMES` frame boundaries.
  - In the off phase, digits with an active `blink_mask` bit behave as blanked.
  - A `load` does not reset the phase.
- Undefined:
  - `blink_mask` is ignored; the port remains, unused.
  - No blink counter or phase logic is built.
  - All other behaviour is identical.

## Test plan
- Reset, `REFRESH_DIV`=8, `BLANK_CYCLES`=2, no load:
  - `ssSel`=1111 for the first 3 output cycles, then 1110 with `ssDisp`=3F for 6 cycles.
  - Then 2 blank cycles, then 1101 with `ssDisp`=3F.
  - `frame_tick` every 32 cycles.
- Load `value`=16'h1A2F, `dp_mask`=4'b0100 mid-frame:
  - `pending`=1 until the boundary.
  - The next frame shows 71, 5B, F7, 06 on digits 0..3.
- Two loads in one frame (16'h1111 then 16'h2222): only 2222 is ever displayed. The 16'h2222 load coincident with the boundary applies immediately and leaves `pending`=0.
- `blank_mask`=4'b1000: digit 3 shows `ssSel`=0111 with `ssDisp`=00; the other digits are unaffected.
- `SS_BLINK_EN`, `BLINK_FRAMES`=2, `blink_mask`=4'b0001: digit 0 alternates lit/dark every 2 frames. Without the macro it is always lit.
- `reset` pulsed mid-slot with `pending`=1: next cycle `ssSel`=1111, `pending`=0, and display resumes at digit 0 showing 3F.
